// File: rtl/cmd_sequencer.sv
// Command sequencer in front of RemoteComm: queues 16-bit Knight commands and
// issues them one at a time, supervising send, progress, completion and timeout.
module cmd_sequencer #(
  parameter int unsigned DEPTH     = 8,
  parameter logic [7:0]  DONE_RESP = 8'hA5,
  parameter logic [7:0]  PROG_RESP = 8'h5A,
  parameter int unsigned TIMEOUT   = 50_000_000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [15:0]              push_cmd,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     start,
  input  logic                     abort,
  output logic [15:0]              cmd,
  output logic                     snd_cmd,
  input  logic                     cmd_snt,
  input  logic                     resp_rdy,
  input  logic [7:0]               resp,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [1:0]               err_code,
  output logic [7:0]               prog_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT) + 1;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_RESP = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_WAIT_SNT,
    S_WAIT_RESP,
    S_DONE,
    S_ERR
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   count_q, count_d;
  logic            full_q, full_d;
  logic [15:0]     cmd_q, cmd_d;
  logic            snd_cmd_q, snd_cmd_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [1:0]      err_code_q, err_code_d;
  logic [7:0]      prog_cnt_q, prog_cnt_d;
  logic [15:0]     mem_q [DEPTH];

  logic            pop;
  logic            flush;
  logic            push_ok;
  logic            timed_out;

  // Next-state, FIFO pointer and output computation
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    err_code_d = err_code_q;
    prog_cnt_d = prog_cnt_q;
    cmd_d      = cmd_q;
    pop        = 1'b0;
    flush      = 1'b0;
    push_ok    = push && !full_q && !abort;
    timed_out  = (timer_q == TW'(TIMEOUT - 1));

    if (abort) begin
      state_d = S_IDLE;
      flush   = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && (count_q != '0)) begin
            state_d    = S_LOAD;
            prog_cnt_d = '0;
            err_code_d = ERR_NONE;
          end
        end
        S_LOAD: begin
          pop     = 1'b1;
          cmd_d   = mem_q[rd_ptr_q[AW-1:0]];
          state_d = S_SEND;
        end
        S_SEND: begin
          state_d = S_WAIT_SNT;
          timer_d = '0;
        end
        S_WAIT_SNT: begin
          if (cmd_snt) begin
            state_d = S_WAIT_RESP;
            timer_d = '0;
          end else if (timed_out) begin
            state_d    = S_ERR;
            err_code_d = ERR_TMO;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        S_WAIT_RESP: begin
          // A same-cycle push counts as queued work when the command completes
          if (resp_rdy) begin
            if (resp == DONE_RESP) begin
              state_d = ((count_q != '0) || push) ? S_LOAD : S_DONE;
            end else if (resp == PROG_RESP) begin
              timer_d = '0;
              if (prog_cnt_q != 8'hFF) prog_cnt_d = prog_cnt_q + 8'd1;
            end else begin
              state_d    = S_ERR;
              err_code_d = ERR_RESP;
            end
          end else if (timed_out) begin
            state_d    = S_ERR;
            err_code_d = ERR_TMO;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        S_DONE: state_d = S_IDLE;
        S_ERR: begin
          if (start) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    wr_ptr_d = flush ? '0 : wr_ptr_q + PW'(push_ok);
    rd_ptr_d = flush ? '0 : rd_ptr_q + PW'(pop);
    count_d  = wr_ptr_d - rd_ptr_d;
    full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
               (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);

    // Strobe follows the SEND cycle so cmd has been stable for a full cycle
    snd_cmd_d = (state_q == S_SEND) && !abort;
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
    err_d     = (state_d == S_ERR);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      cmd_q      <= 16'h0000;
      snd_cmd_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      prog_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      cmd_q      <= cmd_d;
      snd_cmd_q  <= snd_cmd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      prog_cnt_q <= prog_cnt_d;
    end
  end

  // FIFO storage; contents are qualified by the pointers, so no reset needed
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_cmd;
  end

  assign full     = full_q;
  assign count    = count_q;
  assign cmd      = cmd_q;
  assign snd_cmd  = snd_cmd_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign err_code = err_code_q;
  assign prog_cnt = prog_cnt_q;

endmodule

// File: tb/tb_cmd_sequencer.sv
// Self-checking bench for cmd_sequencer: scoreboard of queued commands checked
// against every snd_cmd strobe, plus directed checks on status outputs.
module tb_cmd_sequencer;

  localparam int unsigned DEPTH   = 8;
  localparam int unsigned TIMEOUT = 1000;

  logic        clk;
  logic        rst_n;
  logic        push;
  logic [15:0] push_cmd;
  logic        full;
  logic [3:0]  count;
  logic        start;
  logic        abort;
  logic [15:0] cmd;
  logic        snd_cmd;
  logic        cmd_snt;
  logic        resp_rdy;
  logic [7:0]  resp;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [7:0]  prog_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int snd_seen = 0;
  int done_seen = 0;
  logic [15:0] sb[$];

  cmd_sequencer #(
    .DEPTH    (DEPTH),
    .DONE_RESP(8'hA5),
    .PROG_RESP(8'h5A),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .push_cmd(push_cmd),
    .full    (full),
    .count   (count),
    .start   (start),
    .abort   (abort),
    .cmd     (cmd),
    .snd_cmd (snd_cmd),
    .cmd_snt (cmd_snt),
    .resp_rdy(resp_rdy),
    .resp    (resp),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .err_code(err_code),
    .prog_cnt(prog_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every strobe must carry the oldest outstanding command
  always @(negedge clk) begin
    if (rst_n) begin
      if (snd_cmd) begin
        snd_seen++;
        if (sb.size() == 0) check("snd_unexpected", 32'(sb.size()), 1);
        else check("snd_cmd_order", cmd, sb.pop_front());
      end
      if (done) done_seen++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_push(input logic [15:0] c);
    push = 1'b1;
    push_cmd = c;
    tick();
    push = 1'b0;
    if (sb.size() < DEPTH) sb.push_back(c);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    sb.delete();
  endtask

  task automatic pulse_snt();
    cmd_snt = 1'b1;
    tick();
    cmd_snt = 1'b0;
  endtask

  task automatic pulse_resp(input logic [7:0] r);
    resp_rdy = 1'b1;
    resp = r;
    tick();
    resp_rdy = 1'b0;
  endtask

  task automatic wait_snd(input string tag);
    int n = 0;
    while (!snd_cmd && n < 50) begin
      tick();
      n++;
    end
    check(tag, snd_cmd, 1);
  endtask

  task automatic serve(input logic [7:0] r, input int gap);
    wait_snd("serve_snd");
    repeat (3) tick();
    pulse_snt();
    repeat (gap) tick();
    pulse_resp(r);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    int base;
    rst_n = 1'b0; push = 1'b0; push_cmd = '0; start = 1'b0; abort = 1'b0;
    cmd_snt = 1'b0; resp_rdy = 1'b0; resp = '0;
    repeat (3) tick();
    check("rst_count", count, 0);
    check("rst_full", full, 0);
    check("rst_cmd", cmd, 0);
    check("rst_busy", busy, 0);
    check("rst_err", {err, err_code}, 0);
    check("rst_prog", prog_cnt, 0);
    rst_n = 1'b1;
    tick();

    // Single calibrate command with exact strobe latency
    do_push(16'h2000);
    do_start();
    check("t1_busy", busy, 1);
    tick(); check("t1_snd_k1", snd_cmd, 0);
    tick(); check("t1_snd_k2", snd_cmd, 1);
    check("t1_cmd", cmd, 16'h2000);
    tick(); check("t1_snd_k3", snd_cmd, 0);
    tick(); pulse_snt();
    repeat (4) tick();
    pulse_resp(8'hA5);
    check("t1_done", done, 1);
    tick();
    check("t1_done_once", done, 0);
    check("t1_busy_low", busy, 0);
    check("t1_count", count, 0);
    check("t1_snd_total", snd_seen, 1);

    // Three commands, each released only by the previous completion
    base = snd_seen;
    do_push(16'h4001); do_push(16'h4FF1); do_push(16'h6020);
    check("t2_count", count, 3);
    do_start();
    for (int i = 0; i < 3; i++) begin
      wait_snd("t2_snd");
      repeat (2) tick();
      pulse_snt();
      repeat (20) tick();
      check("t2_no_early_snd", snd_seen, base + i + 1);
      pulse_resp(8'hA5);
    end
    check("t2_done", done, 1);
    tick();
    check("t2_done_total", done_seen, 2);
    check("t2_snd_total", snd_seen, base + 3);

    // Tour: progress bytes keep the command alive past TIMEOUT
    do_push(16'h6022);
    do_start();
    wait_snd("t3_snd");
    repeat (2) tick();
    pulse_snt();
    for (int i = 0; i < 24; i++) begin
      repeat (899) tick();
      pulse_resp(8'h5A);
    end
    check("t3_prog", prog_cnt, 24);
    check("t3_no_err", err, 0);
    repeat (899) tick();
    pulse_resp(8'hA5);
    check("t3_done", done, 1);
    tick();

    // Bad response stops with the rest of the queue intact
    do_push(16'h1111); do_push(16'h2222); do_push(16'h3333);
    do_start();
    check("t4_prog_clr", prog_cnt, 0);
    wait_snd("t4_snd");
    tick();
    pulse_snt();
    tick();
    pulse_resp(8'h3C);
    check("t4_err", err, 1);
    check("t4_code", err_code, 2'b01);
    check("t4_count", count, sb.size());
    repeat (5) tick();
    check("t4_err_hold", err, 1);
    do_abort();
    check("t4_abort_count", count, 0);
    check("t4_abort_busy", busy, 0);
    check("t4_abort_err", err, 0);

    // Timeout: error exactly TIMEOUT cycles after the strobe
    do_push(16'h5555);
    do_start();
    wait_snd("t5_snd");
    repeat (TIMEOUT - 1) tick();
    check("t5_err_early", err, 0);
    tick();
    check("t5_err", err, 1);
    check("t5_code", err_code, 2'b10);
    do_abort();

    // cmd_snt on the last possible cycle beats the timeout
    do_push(16'h5556);
    do_start();
    check("t5b_code_clr", err_code, 0);
    wait_snd("t5b_snd");
    repeat (TIMEOUT - 1) tick();
    cmd_snt = 1'b1;
    tick();
    cmd_snt = 1'b0;
    check("t5b_no_err", err, 0);
    check("t5b_busy", busy, 1);
    repeat (2) tick();
    pulse_resp(8'hA5);
    check("t5b_done", done, 1);
    tick();

    // Overfill, then a push coinciding with the final completion
    for (int i = 0; i < DEPTH + 2; i++) do_push(16'hC000 + 16'(i));
    check("t6_full", full, 1);
    check("t6_count", count, DEPTH);
    do_start();
    for (int i = 0; i < DEPTH - 1; i++) serve(8'hA5, 2);
    wait_snd("t6_last_snd");
    repeat (2) tick();
    pulse_snt();
    repeat (2) tick();
    push = 1'b1; push_cmd = 16'h7777; resp_rdy = 1'b1; resp = 8'hA5;
    tick();
    push = 1'b0; resp_rdy = 1'b0;
    sb.push_back(16'h7777);
    check("t6_no_done", done, 0);
    check("t6_busy", busy, 1);
    serve(8'hA5, 2);
    check("t6_done", done, 1);
    tick();
    check("t6_sb_empty", sb.size(), 0);

    // Asynchronous reset while waiting for cmd_snt
    do_push(16'h8888);
    do_start();
    wait_snd("t7_snd");
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("t7_busy", busy, 0);
    check("t7_cmd", cmd, 0);
    check("t7_count", count, 0);
    check("t7_snd", snd_cmd, 0);
    sb.delete();
    base = snd_seen;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    check("t7_no_strobe", snd_seen, base);
    check("t7_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
